// File: rtl/qea_host_sequencer_if.sv
// Signal bundle between the QEA host sequencer and its environment: job control, context
// stream, QEA context/state RAM ports, start/complete and the state readout stream.
interface qea_host_sequencer_if #(
  parameter int unsigned PE_NUM           = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned MAX_QBIT_WIDTH   = 6,
  parameter int unsigned MAX_QBIT_NUM     = 16,
  parameter int unsigned STATE_ADDR_WIDTH = 16,
  parameter int unsigned CTX_ADDR_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH        = 32
);
  localparam int unsigned RowW = PE_NUM * 2 * DATA_WIDTH;

  logic                        i_launch;
  logic                        i_abort;
  logic [MAX_QBIT_WIDTH-1:0]   i_qbit_num;
  logic [CTX_ADDR_WIDTH:0]     i_ins_num;
  logic [MAX_QBIT_NUM-1:0]     i_init_basis;
  logic                        i_ctx_valid;
  logic [2*DATA_WIDTH-1:0]     i_ctx_data;
  logic                        o_ctx_ready;
  logic                        o_ctx_en;
  logic                        o_ctx_wea;
  logic [CTX_ADDR_WIDTH-1:0]   o_ctx_addr;
  logic [2*DATA_WIDTH-1:0]     o_ctx_wdata;
  logic                        o_state_ena;
  logic                        o_state_wea;
  logic [STATE_ADDR_WIDTH-1:0] o_state_addra;
  logic [RowW-1:0]             o_state_dina;
  logic [RowW-1:0]             i_state_dout;
  logic                        o_start;
  logic                        i_complete;
  logic                        o_rd_valid;
  logic [RowW-1:0]             o_rd_data;
  logic                        o_rd_last;
  logic                        i_rd_ready;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_error;
  logic [CNT_WIDTH-1:0]        o_cycle_count;

  modport master (
    input  i_launch, i_abort, i_qbit_num, i_ins_num, i_init_basis, i_ctx_valid, i_ctx_data,
           i_state_dout, i_complete, i_rd_ready,
    output o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_wdata, o_state_ena, o_state_wea,
           o_state_addra, o_state_dina, o_start, o_rd_valid, o_rd_data, o_rd_last, o_busy,
           o_done, o_error, o_cycle_count
  );

  modport slave (
    output i_launch, i_abort, i_qbit_num, i_ins_num, i_init_basis, i_ctx_valid, i_ctx_data,
           i_state_dout, i_complete, i_rd_ready,
    input  o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_wdata, o_state_ena, o_state_wea,
           o_state_addra, o_state_dina, o_start, o_rd_valid, o_rd_data, o_rd_last, o_busy,
           o_done, o_error, o_cycle_count
  );
endinterface

// File: rtl/qea_host_sequencer.sv
// Host-side sequencer for the QEA core: loads context, seeds a basis state, runs the core
// with a timeout and streams the final state vector out row by row.
module qea_host_sequencer #(
  parameter int unsigned PE_NUM_WIDTH     = 2,
  parameter int unsigned PE_NUM           = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NUM_FRAC_BIT     = 30,
  parameter int unsigned MAX_QBIT_WIDTH   = 6,
  parameter int unsigned MAX_QBIT_NUM     = 16,
  parameter int unsigned STATE_ADDR_WIDTH = 16,
  parameter int unsigned CTX_ADDR_WIDTH   = 16,
  parameter int unsigned READ_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES   = 2**24,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  qea_host_sequencer_if.master bus
);
  localparam int unsigned LaneW = 2 * DATA_WIDTH;
  localparam int unsigned RowW  = PE_NUM * LaneW;
  localparam int unsigned InsW  = CTX_ADDR_WIDTH + 1;
  localparam int unsigned RowsW = STATE_ADDR_WIDTH + 1;
  localparam int unsigned LatW  = $clog2(READ_LATENCY + 1);
  localparam logic [DATA_WIDTH-1:0] One         = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [CNT_WIDTH-1:0]  TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StLoadCtx, StInit, StStart, StRun, StRdIssue, StRdWait, StRdHold
  } state_e;

  state_e                      state_q;
  logic [InsW-1:0]             ins_num_q, ctx_cnt_q;
  logic [STATE_ADDR_WIDTH-1:0] last_row_q, k_row_q, row_q;
  logic [PE_NUM_WIDTH-1:0]     k_lane_q;
  logic [LatW-1:0]             lat_q;
  logic [CNT_WIDTH-1:0]        cnt_q, cycle_count_q;
  logic                        ctx_ready_q, ctx_en_q, state_ena_q, state_wea_q, start_q;
  logic                        rd_valid_q, rd_last_q, done_q, error_q;
  logic [CTX_ADDR_WIDTH-1:0]   ctx_addr_q;
  logic [LaneW-1:0]            ctx_wdata_q;
  logic [STATE_ADDR_WIDTH-1:0] state_addr_q;
  logic [RowW-1:0]             state_din_q, rd_data_q, init_row;
  logic [MAX_QBIT_WIDTH-1:0]   row_shift;
  logic [STATE_ADDR_WIDTH-1:0] last_row_d;
  logic                        launch_bad;

  assign launch_bad = (bus.i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
                   || (bus.i_qbit_num > MAX_QBIT_WIDTH'(MAX_QBIT_NUM))
                   || (bus.i_ins_num == '0)
                   || (bus.i_ins_num > (InsW'(1) << CTX_ADDR_WIDTH))
                   || ((bus.i_init_basis >> bus.i_qbit_num) != '0);

  assign row_shift  = bus.i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign last_row_d = STATE_ADDR_WIDTH'((RowsW'(1) << row_shift) - RowsW'(1));

  // Lane 0 sits in the top slice of a row; the real part is the upper half of a lane.
  always_comb begin
    init_row = '0;
    for (int l = 0; l < PE_NUM; l++) begin
      if (PE_NUM_WIDTH'(l) == k_lane_q) begin
        init_row[(PE_NUM - 1 - l) * LaneW + DATA_WIDTH +: DATA_WIDTH] = One;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ins_num_q     <= '0;
      ctx_cnt_q     <= '0;
      last_row_q    <= '0;
      k_row_q       <= '0;
      k_lane_q      <= '0;
      row_q         <= '0;
      lat_q         <= '0;
      cnt_q         <= '0;
      cycle_count_q <= '0;
      ctx_ready_q   <= 1'b0;
      ctx_en_q      <= 1'b0;
      ctx_addr_q    <= '0;
      ctx_wdata_q   <= '0;
      state_ena_q   <= 1'b0;
      state_wea_q   <= 1'b0;
      state_addr_q  <= '0;
      state_din_q   <= '0;
      start_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_last_q     <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      ctx_en_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      if (bus.i_abort) begin
        state_q     <= StIdle;
        ctx_ready_q <= 1'b0;
        state_ena_q <= 1'b0;
        state_wea_q <= 1'b0;
        rd_valid_q  <= 1'b0;
        rd_last_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.i_launch) begin
              if (launch_bad) begin
                error_q <= 1'b1;
              end else begin
                error_q     <= 1'b0;
                ins_num_q   <= bus.i_ins_num;
                last_row_q  <= last_row_d;
                k_row_q     <= STATE_ADDR_WIDTH'(bus.i_init_basis >> PE_NUM_WIDTH);
                k_lane_q    <= bus.i_init_basis[PE_NUM_WIDTH-1:0];
                ctx_cnt_q   <= '0;
                ctx_ready_q <= 1'b1;
                state_q     <= StLoadCtx;
              end
            end
          end
          StLoadCtx: begin
            if (bus.i_ctx_valid && ctx_ready_q) begin
              ctx_en_q    <= 1'b1;
              ctx_addr_q  <= ctx_cnt_q[CTX_ADDR_WIDTH-1:0];
              ctx_wdata_q <= bus.i_ctx_data;
              ctx_cnt_q   <= ctx_cnt_q + InsW'(1);
              if (ctx_cnt_q == ins_num_q - InsW'(1)) begin
                ctx_ready_q <= 1'b0;
                row_q       <= '0;
                state_q     <= StInit;
              end
            end
          end
          StInit: begin
            state_ena_q  <= 1'b1;
            state_wea_q  <= 1'b1;
            state_addr_q <= row_q;
            state_din_q  <= (row_q == k_row_q) ? init_row : '0;
            row_q        <= row_q + STATE_ADDR_WIDTH'(1);
            if (row_q == last_row_q) state_q <= StStart;
          end
          StStart: begin
            state_ena_q <= 1'b0;
            state_wea_q <= 1'b0;
            start_q     <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StRun;
          end
          StRun: begin
            if (!(&cnt_q)) cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (bus.i_complete) begin
              cycle_count_q <= cnt_q;
              row_q         <= '0;
              state_ena_q   <= 1'b1;
              state_addr_q  <= '0;
              state_q       <= StRdIssue;
            end else if (cnt_q >= TimeoutLast) begin
              error_q <= 1'b1;
              state_q <= StIdle;
            end
          end
          StRdIssue: begin
            state_ena_q <= 1'b0;
            lat_q       <= LatW'(1);
            state_q     <= StRdWait;
          end
          StRdWait: begin
            if (lat_q == LatW'(READ_LATENCY)) begin
              rd_data_q  <= bus.i_state_dout;
              rd_valid_q <= 1'b1;
              rd_last_q  <= (row_q == last_row_q);
              state_q    <= StRdHold;
            end else begin
              lat_q <= lat_q + LatW'(1);
            end
          end
          StRdHold: begin
            if (bus.i_rd_ready) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              if (row_q == last_row_q) begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                row_q        <= row_q + STATE_ADDR_WIDTH'(1);
                state_ena_q  <= 1'b1;
                state_addr_q <= row_q + STATE_ADDR_WIDTH'(1);
                state_q      <= StRdIssue;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.o_ctx_ready   = ctx_ready_q;
  assign bus.o_ctx_en      = ctx_en_q;
  assign bus.o_ctx_wea     = ctx_en_q;
  assign bus.o_ctx_addr    = ctx_addr_q;
  assign bus.o_ctx_wdata   = ctx_wdata_q;
  assign bus.o_state_ena   = state_ena_q;
  assign bus.o_state_wea   = state_wea_q;
  assign bus.o_state_addra = state_addr_q;
  assign bus.o_state_dina  = state_din_q;
  assign bus.o_start       = start_q;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_rd_last     = rd_last_q;
  assign bus.o_busy        = (state_q != StIdle);
  assign bus.o_done        = done_q;
  assign bus.o_error       = error_q;
  assign bus.o_cycle_count = cycle_count_q;
endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer: a full 4-qubit job, basis seeding, invalid launches,
// run timeout, abort during context load and reset during readout.
module tb_qea_host_sequencer;
  localparam int unsigned RW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qea_host_sequencer_if bus ();

  qea_host_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [RW-1:0] row_pat(input logic [15:0] r);
    logic [RW-1:0] v;
    for (int l = 0; l < 8; l++) v[l*32 +: 32] = {16'hA5C0 + 16'(l), r};
    return v;
  endfunction

  function automatic logic [63:0] word(input int i);
    return {32'hC7C7_0000 | 32'(i), ~32'(i)};
  endfunction

  // State RAM stand-in: one-cycle read returning a fixed per-row pattern.
  logic [RW-1:0] dout_q;
  always @(posedge clk) begin
    if (bus.o_state_ena && !bus.o_state_wea) dout_q <= row_pat(bus.o_state_addra);
  end
  assign bus.i_state_dout = dout_q;

  logic [15:0]   ctx_addr_log[$];
  logic [63:0]   ctx_data_log[$];
  logic [15:0]   init_addr_log[$];
  logic [RW-1:0] init_data_log[$];
  int start_cnt = 0, done_cnt = 0, strobe_cnt = 0;
  always @(negedge clk) begin
    if (bus.o_ctx_en) begin
      ctx_addr_log.push_back(bus.o_ctx_addr);
      ctx_data_log.push_back(bus.o_ctx_wdata);
    end
    if (bus.o_state_ena && bus.o_state_wea) begin
      init_addr_log.push_back(bus.o_state_addra);
      init_data_log.push_back(bus.o_state_dina);
    end
    if (bus.o_start) start_cnt++;
    if (bus.o_done) done_cnt++;
    if (bus.o_ctx_en || bus.o_ctx_wea || bus.o_state_ena || bus.o_state_wea || bus.o_start)
      strobe_cnt++;
  end

  int n_pass = 0, n_total = 0, n_fail = 0;
  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask

  task automatic launch(input int q, input int ins, input int k);
    cyc();
    bus.i_launch     = 1'b1;
    bus.i_qbit_num   = 6'(q);
    bus.i_ins_num    = 17'(ins);
    bus.i_init_basis = 16'(k);
    cyc();
    bus.i_launch = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        bus.i_ctx_valid = 1'b0;
        cyc();
      end
      bus.i_ctx_valid = 1'b1;
      bus.i_ctx_data  = word(i);
      cyc();
    end
    bus.i_ctx_valid = 1'b0;
  endtask

  // sel: 0 = o_start, 1 = o_rd_valid
  task automatic wait_hi(input int sel, input int lim, input string tag);
    bit seen = 1'b0;
    int i = 0;
    while (!seen && i < lim) begin
      smp();
      i++;
      seen = (sel == 0) ? bus.o_start : bus.o_rd_valid;
    end
    check(tag, seen, 1);
  endtask

  task automatic bad_launch(input string tag, input int q, input int ins, input int k);
    int sb;
    launch(2, 1, 0);
    bus.i_abort = 1'b1;
    cyc();
    bus.i_abort = 1'b0;
    smp();
    check({tag, "_pre_err"}, bus.o_error, 0);
    sb = strobe_cnt;
    launch(q, ins, k);
    smp();
    check({tag, "_err"}, bus.o_error, 1);
    check({tag, "_busy"}, bus.o_busy, 0);
    repeat (3) smp();
    check({tag, "_strobes"}, 32'(strobe_cnt - sb), 0);
  endtask

  initial begin
    int cb, ib, sb, db, bad;
    bus.i_launch = 0; bus.i_abort = 0; bus.i_qbit_num = 0; bus.i_ins_num = 0;
    bus.i_init_basis = 0; bus.i_ctx_valid = 0; bus.i_ctx_data = 0; bus.i_complete = 0;
    bus.i_rd_ready = 0;

    #12;
    check("rst_busy", bus.o_busy, 0);
    check("rst_ready", bus.o_ctx_ready, 0);
    check("rst_valid", bus.o_rd_valid, 0);
    check("rst_err", bus.o_error, 0);
    check("rst_cnt", bus.o_cycle_count, 0);
    #10 rst_n = 1'b1;

    // Full job: qbit 4, 65 words with gaps, k = 0.
    cb = ctx_addr_log.size(); ib = init_addr_log.size(); sb = start_cnt; db = done_cnt;
    launch(4, 65, 0);
    check("load_ready", bus.o_ctx_ready, 1);
    feed(65, 1'b1);
    smp();
    check("ready_drop", bus.o_ctx_ready, 0);
    wait_hi(0, 20, "start_seen");
    check("ctx_count", 32'(ctx_addr_log.size() - cb), 65);
    bad = 0;
    for (int i = 0; i < 65; i++)
      if (ctx_addr_log[cb+i] !== 16'(i) || ctx_data_log[cb+i] !== word(i)) bad++;
    check("ctx_order", 32'(bad), 0);
    check("init_count", 32'(init_addr_log.size() - ib), 4);
    bad = 0;
    for (int i = 0; i < 4; i++) if (init_addr_log[ib+i] !== 16'(i)) bad++;
    check("init_addr", 32'(bad), 0);
    check("init_row0", init_data_log[ib], 256'h4000_0000_0000_0000 << 192);
    check("init_rest", init_data_log[ib+1] | init_data_log[ib+2] | init_data_log[ib+3], 0);
    check("start_once", 32'(start_cnt - sb), 1);
    // Complete 37 cycles after o_start; a launch while busy must be ignored.
    repeat (5) cyc();
    bus.i_launch = 1'b1; bus.i_qbit_num = 6'd1;
    cyc();
    bus.i_launch = 1'b0;
    repeat (31) cyc();
    bus.i_complete = 1'b1;
    cyc();
    bus.i_complete = 1'b0;
    smp();
    check("cycle_count", bus.o_cycle_count, 37);
    check("busy_launch_ignored", bus.o_error, 0);
    for (int r = 0; r < 4; r++) begin
      wait_hi(1, 10, "rd_valid_seen");
      check("rd_data", bus.o_rd_data, row_pat(16'(r)));
      check("rd_last", bus.o_rd_last, r == 3);
      if (r % 2 == 0) begin
        repeat (2) smp();
        check("rd_hold_valid", bus.o_rd_valid, 1);
        check("rd_hold_data", bus.o_rd_data, row_pat(16'(r)));
      end
      bus.i_rd_ready = 1'b1;
      cyc();
      bus.i_rd_ready = 1'b0;
    end
    smp();
    check("done_once", 32'(done_cnt - db), 1);
    check("idle_after_job", bus.o_busy, 0);

    // k = 6 seeds row 1 lane 2; abort in RUN keeps count and error.
    ib = init_addr_log.size();
    launch(4, 1, 6);
    feed(1, 1'b0);
    wait_hi(0, 20, "start_seen_k6");
    check("k6_row0", init_data_log[ib], 0);
    check("k6_row1", init_data_log[ib+1], 256'h4000_0000_0000_0000 << 64);
    check("k6_rest", init_data_log[ib+2] | init_data_log[ib+3], 0);
    bus.i_abort = 1'b1;
    cyc();
    bus.i_abort = 1'b0;
    smp();
    check("abort_run_busy", bus.o_busy, 0);
    check("abort_run_cnt", bus.o_cycle_count, 37);
    check("abort_run_err", bus.o_error, 0);

    bad_launch("qbit1", 1, 1, 0);
    bad_launch("k16", 4, 1, 16);
    bad_launch("ins0", 4, 0, 0);
    bad_launch("qbit17", 17, 1, 0);
    bad_launch("ins_big", 4, 65537, 0);

    // Timeout: qbit 2 (one row, k = 3 in lane 3), no completion.
    ib = init_addr_log.size(); db = done_cnt;
    launch(2, 1, 3);
    check("relaunch_clears_err", bus.o_error, 0);
    feed(1, 1'b0);
    wait_hi(0, 20, "start_seen_to");
    check("to_init_count", 32'(init_addr_log.size() - ib), 1);
    check("to_init_row", init_data_log[ib], 256'h4000_0000_0000_0000);
    repeat (99) smp();
    check("to_busy_c99", bus.o_busy, 1);
    check("to_err_c99", bus.o_error, 0);
    smp();
    check("to_busy_c100", bus.o_busy, 0);
    check("to_err_c100", bus.o_error, 1);
    check("to_no_done", 32'(done_cnt - db), 0);
    check("to_cnt_kept", bus.o_cycle_count, 37);

    // Abort during context load at word 10.
    cb = ctx_addr_log.size();
    launch(4, 20, 0);
    feed(10, 1'b0);
    bus.i_ctx_valid = 1'b1; bus.i_ctx_data = word(10); bus.i_abort = 1'b1;
    cyc();
    bus.i_ctx_valid = 1'b0; bus.i_abort = 1'b0;
    smp();
    sb = strobe_cnt;
    check("abort_ld_busy", bus.o_busy, 0);
    check("abort_ld_ready", bus.o_ctx_ready, 0);
    check("abort_ld_writes", 32'(ctx_addr_log.size() - cb), 10);
    repeat (3) smp();
    check("abort_ld_quiet", 32'(strobe_cnt - sb), 0);

    // Reset during readout.
    launch(3, 1, 0);
    feed(1, 1'b0);
    wait_hi(0, 20, "start_seen_rst");
    repeat (5) cyc();
    bus.i_complete = 1'b1;
    cyc();
    bus.i_complete = 1'b0;
    wait_hi(1, 10, "rd_valid_rst");
    check("rst_run_cnt", bus.o_cycle_count, 5);
    check("rst_run_data", bus.o_rd_data, row_pat(16'd0));
    check("rst_run_last", bus.o_rd_last, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.o_busy, 0);
    check("arst_valid", bus.o_rd_valid, 0);
    check("arst_data", bus.o_rd_data, 0);
    check("arst_cnt", bus.o_cycle_count, 0);
    check("arst_strobes", {bus.o_state_ena, bus.o_ctx_en, bus.o_start, bus.o_done}, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
